// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue: sequential fetch, credit-limited imem requests, FIFO to ID, redirect flush.
// Optional same-cycle response bypass to ID when IF_PREFETCH_BYPASS_EN is defined.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc,
  output logic [63:0] id_pc_next
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [63:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d, inflight_q, inflight_d, discard_q, discard_d;
  logic [31:0]   fifo_instr_q [DEPTH];
  logic [63:0]   fifo_pc_q    [DEPTH];

  logic          req_fire, rsp_keep, byp, push, pop;
  logic [CW:0]   credit_used;
  logic [63:0]   redirect_tgt;

  assign redirect_tgt   = {redirect_pc[63:2], 2'b00};
  assign credit_used    = {1'b0, count_q} + {1'b0, inflight_q};
  assign imem_req_valid = !reset && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && !redirect_valid && !reset && (discard_q == '0);

`ifdef IF_PREFETCH_BYPASS_EN
  assign byp = rsp_keep && (count_q == '0);
`else
  assign byp = 1'b0;
`endif

  assign id_valid   = !reset && ((count_q != '0) || byp);
  assign id_instr   = byp ? imem_rsp_data : fifo_instr_q[rd_ptr_q];
  assign id_pc      = byp ? rsp_pc_q      : fifo_pc_q[rd_ptr_q];
  assign id_pc_next = id_pc + 64'd4;
  assign pop        = id_valid && id_ready && (count_q != '0);
  assign push       = rsp_keep && !(byp && id_ready);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    discard_d  = discard_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
    if (redirect_valid) begin
      fetch_pc_d = redirect_tgt;
      rsp_pc_d   = redirect_tgt;
      rd_ptr_d   = wr_ptr_q;
      count_d    = '0;
      // inflight already includes responses owed by earlier redirects, so
      // every outstanding response not arriving this cycle is now stale.
      discard_d  = inflight_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 64'd4;
      if (rsp_keep) rsp_pc_d = rsp_pc_q + 64'd4;
      if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  // Storage has no reset; entries are only observed once count marks them valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
      fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
    end
    if (!reset && push) assert (count_q != CW'(DEPTH));
  end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Scoreboard bench for if_prefetch_queue: latency-L memory model, expected-PC queue, decoupled monitor.
module tb_if_prefetch_queue;
  logic        clk = 1'b0, reset = 1'b1;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [63:0] imem_req_addr, redirect_pc, id_pc, id_pc_next;
  logic [31:0] imem_rsp_data, id_instr;
  logic        redirect_valid, id_valid, id_ready;

`ifdef IF_PREFETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_next(id_pc_next)
  );

  always #5 clk = ~clk;

  int          cyc = 0, lat = 1, acc_cnt = 0, n_checks = 0, n_errors = 0;
  bit          stall_mode = 1'b0, hold = 1'b0;
  logic [63:0] exp_q[$], mem_addr_q[$];
  int          mem_due_q[$], pop_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instruction memory: fixed latency, in order, flushed by reset.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_req_ready = 1'b1;
    forever begin
      @(negedge clk);
      imem_req_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mem_due_q.size() > 0 && mem_due_q[0] == cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(mem_addr_q.pop_front());
        void'(mem_due_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
      #2;
      if (reset) begin
        mem_addr_q.delete();
        mem_due_q.delete();
        imem_rsp_valid = 1'b0;
      end else if (imem_req_valid && imem_req_ready) begin
        chk("req_align", {62'b0, imem_req_addr[1:0]}, 64'h0);
        mem_addr_q.push_back(imem_req_addr);
        mem_due_q.push_back(cyc + lat);
        acc_cnt++;
      end
    end
  end

  // ID consumes only while the scoreboard expects something.
  initial begin
    id_ready = 1'b0;
    forever begin
      @(negedge clk);
      #1 id_ready = !hold && (exp_q.size() > 0);
    end
  end

  // Monitor: compare every consumed instruction against the scoreboard head.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pop: got pc %h expected no instruction", id_pc);
        end else begin
          e = exp_q.pop_front();
          chk("id_pc", id_pc, e);
          chk("id_instr", {32'b0, id_instr}, {32'b0, instr_of(e)});
          chk("id_pc_next", id_pc_next, e + 64'd4);
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic push_seq(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 64'(4 * i));
  endtask

  // Returns at the start of the first cycle with reset released.
  task automatic start(input int l, input bit stall);
    @(negedge clk);
    reset = 1'b1; lat = l; stall_mode = stall; redirect_valid = 1'b0;
    pop_cyc.delete();
    @(negedge clk);
    #3;
    chk("rst_req_valid", {63'b0, imem_req_valid}, 64'h0);
    chk("rst_id_valid", {63'b0, id_valid}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_drain: got %0d entries left expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int c0, tr, base;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // 1: free run, L=1
    start(1, 1'b0);
    c0 = cyc;
    push_seq(64'h0, 12);
    drain("t1", 100);
    if (pop_cyc.size() == 12) begin
      chk("t1_first_lat", 64'(pop_cyc[0] - c0), 64'(2 - BYP));
      chk("t1_throughput", 64'(pop_cyc[11] - pop_cyc[0]), 64'd11);
    end

    // 2: backpressure fill then drain
    start(1, 1'b0);
    base = acc_cnt;
    repeat (10) @(negedge clk);
    #3;
    chk("t2_accepts", 64'(acc_cnt - base), 64'd4);
    chk("t2_req_valid", {63'b0, imem_req_valid}, 64'h0);
    chk("t2_id_valid", {63'b0, id_valid}, 64'h1);
    chk("t2_head_pc", id_pc, 64'h0);
    push_seq(64'h0, 6);
    drain("t2", 100);

    // 3: redirect with two in flight, L=3
    start(3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 64'h100; tr = cyc;
    push_seq(64'h100, 8);
    #3 chk("t3_no_req_on_redirect", {63'b0, imem_req_valid}, 64'h0);
    @(negedge clk);
    redirect_valid = 1'b0;
    drain("t3", 100);
    if (pop_cyc.size() > 0) chk("t3_target_lat", 64'(pop_cyc[0] - tr), 64'(5 - BYP));

    // 4: redirect coincident with response and pop, then second redirect
    start(2, 1'b0);
    push_seq(64'h0, 1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 64'h180;
    @(negedge clk);
    redirect_pc = 64'h200;
    push_seq(64'h200, 8);
    #3 chk("t4_flushed", {63'b0, id_valid}, 64'h0);
    @(negedge clk);
    redirect_valid = 1'b0;
    drain("t4", 100);

    // 5: misaligned target at top of address space wraps to 0
    start(1, 1'b0);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    push_seq(64'h0, 3);
    @(negedge clk);
    redirect_valid = 1'b0;
    #3 chk("t5_wrap_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    drain("t5", 100);

    // 6: reset mid-stream with three buffered
    hold = 1'b1;
    start(1, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #3;
    chk("t6_rst_id_valid", {63'b0, id_valid}, 64'h0);
    chk("t6_rst_req_valid", {63'b0, imem_req_valid}, 64'h0);
    @(negedge clk);
    #3;
    chk("t6_after_id_valid", {63'b0, id_valid}, 64'h0);
    chk("t6_after_req_valid", {63'b0, imem_req_valid}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    push_seq(64'h0, 3);
    hold = 1'b0;
    #3;
    chk("t6_restart_valid", {63'b0, imem_req_valid}, 64'h1);
    chk("t6_restart_addr", imem_req_addr, 64'h0);
    drain("t6", 100);

    // 7: random request-ready stalls, L=2
    start(2, 1'b1);
    push_seq(64'h0, 8);
    drain("t7", 300);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end
endmodule
